// File: rtl/verify_scheduler.sv
// Buffers UART RX bytes, paces them into the sequence checker one per GAP clocks,
// and returns one verdict byte per NUL-terminated frame over the UART TX handshake.
module verify_scheduler #(
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned GAP        = 10,
   parameter int unsigned TIMEOUT    = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [7:0] ascii_char,
   output logic       char_valid,
   input  logic       sequence_valid,
   input  logic       output_strobe,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       busy,
   output logic       overflow,
   output logic [7:0] pass_cnt,
   output logic [7:0] fail_cnt
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned GW = $clog2(GAP);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
   localparam logic [GW-1:0] GAP_M1   = GW'(GAP - 1);
   localparam logic [TW-1:0] TO_M1    = TW'(TIMEOUT - 1);
   localparam logic [7:0]    CH_Y = 8'h59;
   localparam logic [7:0]    CH_N = 8'h4E;
   localparam logic [7:0]    CH_T = 8'h54;

   typedef enum logic [1:0] {S_IDLE, S_FEED, S_WAIT, S_RESP} state_t;

   state_t        state_q, state_d;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [TW-1:0] to_q, to_d;
   logic          seen_q, seen_d;
   logic [7:0]    ascii_q, ascii_d, tx_data_q, tx_data_d;
   logic [7:0]    pass_q, pass_d, fail_q, fail_d;
   logic          char_valid_q, char_valid_d, tx_valid_q, tx_valid_d, ovf_q, ovf_d;
   logic          empty, full, push, pop;
   logic [7:0]    head;

   assign empty = (count_q == '0);
   assign full  = (count_q == FULL_CNT);
   assign head  = mem_q[rd_ptr_q];

   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      gap_d        = gap_q;
      to_d         = to_q;
      seen_d       = seen_q;
      ascii_d      = ascii_q;
      tx_data_d    = tx_data_q;
      tx_valid_d   = tx_valid_q;
      pass_d       = pass_q;
      fail_d       = fail_q;
      ovf_d        = ovf_q;
      char_valid_d = 1'b0;
      pop          = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!empty) begin
               state_d = S_FEED;
               gap_d   = GAP_M1;
            end
         end
         S_FEED: begin
            if (gap_q != '0) begin
               gap_d = gap_q - 1'b1;
            end else if (!empty) begin
               pop          = 1'b1;
               ascii_d      = head;
               char_valid_d = 1'b1;
               gap_d        = GAP_M1;
               // A NUL only ends the frame once payload has been seen; leading NULs are just fed.
               if (head != 8'h00) begin
                  seen_d = 1'b1;
               end else if (seen_q) begin
                  seen_d  = 1'b0;
                  to_d    = '0;
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (output_strobe) begin
               tx_data_d  = sequence_valid ? CH_Y : CH_N;
               tx_valid_d = 1'b1;
               state_d    = S_RESP;
            end else if (to_q == TO_M1) begin
               tx_data_d  = CH_T;
               tx_valid_d = 1'b1;
               state_d    = S_RESP;
            end else begin
               to_d = to_q + 1'b1;
            end
         end
         S_RESP: begin
            if (tx_ready) begin
               tx_valid_d = 1'b0;
               state_d    = S_IDLE;
               if (tx_data_q == CH_Y) begin
                  if (pass_q != 8'hFF) pass_d = pass_q + 1'b1;
               end else if (fail_q != 8'hFF) begin
                  fail_d = fail_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A pop on the same cycle frees the slot, so a full FIFO still accepts the byte.
      push = rx_valid && (!full || pop);
      if (rx_valid && !push) ovf_d = 1'b1;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= rx_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         gap_q        <= '0;
         to_q         <= '0;
         seen_q       <= 1'b0;
         ascii_q      <= '0;
         tx_data_q    <= '0;
         tx_valid_q   <= 1'b0;
         pass_q       <= '0;
         fail_q       <= '0;
         ovf_q        <= 1'b0;
         char_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         gap_q        <= gap_d;
         to_q         <= to_d;
         seen_q       <= seen_d;
         ascii_q      <= ascii_d;
         tx_data_q    <= tx_data_d;
         tx_valid_q   <= tx_valid_d;
         pass_q       <= pass_d;
         fail_q       <= fail_d;
         ovf_q        <= ovf_d;
         char_valid_q <= char_valid_d;
      end
   end

   assign ascii_char = ascii_q;
   assign char_valid = char_valid_q;
   assign tx_data    = tx_data_q;
   assign tx_valid   = tx_valid_q;
   assign busy       = (state_q != S_IDLE);
   assign overflow   = ovf_q;
   assign pass_cnt   = pass_q;
   assign fail_cnt   = fail_q;

endmodule

// File: tb/tb_verify_scheduler.sv
// Directed plus randomized frames checked against a queue-level model of the scheduler.
module tb_verify_scheduler;

   localparam int unsigned DEPTH   = 16;
   localparam int unsigned GAP     = 10;
   localparam int unsigned TIMEOUT = 64;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] ascii_char;
   logic       char_valid;
   logic       sequence_valid;
   logic       output_strobe;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       busy;
   logic       overflow;
   logic [7:0] pass_cnt;
   logic [7:0] fail_cnt;

   verify_scheduler #(.FIFO_DEPTH(DEPTH), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .ascii_char(ascii_char), .char_valid(char_valid),
      .sequence_valid(sequence_valid), .output_strobe(output_strobe),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .busy(busy), .overflow(overflow), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned t;
      logic [7:0]  b;
   } feed_t;

   feed_t       feed_q[$];
   logic [7:0]  frame_q[$];
   logic [7:0]  burst_q[$];
   logic [7:0]  kept_q[$];
   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   int unsigned exp_pass = 0;
   int unsigned exp_fail = 0;
   logic [7:0]  exp_res;

   // Every feed strobe is logged with the edge index that produced it.
   always @(negedge clk) begin
      if (!rst && char_valid) feed_q.push_back('{t: cyc, b: ascii_char});
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: observed still running expected finished");
      $fatal(1);
   end

   task tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_ascii"}, ascii_char, 0);
      check({tag, "_cv"},    char_valid, 0);
      check({tag, "_txd"},   tx_data, 0);
      check({tag, "_txv"},   tx_valid, 0);
      check({tag, "_busy"},  busy, 0);
      check({tag, "_ovf"},   overflow, 0);
      check({tag, "_pass"},  pass_cnt, 0);
      check({tag, "_fail"},  fail_cnt, 0);
   endtask

   task automatic load_str(input string s);
      frame_q.delete();
      frame_q.push_back(8'h00);
      for (int i = 0; i < s.len(); i++) frame_q.push_back(s[i]);
      frame_q.push_back(8'h00);
   endtask

   task automatic build_frame(input int unsigned len, input bit lead);
      frame_q.delete();
      if (lead) frame_q.push_back(8'h00);
      for (int unsigned i = 0; i < len; i++) frame_q.push_back(8'($urandom_range(1, 255)));
      frame_q.push_back(8'h00);
   endtask

   task automatic send_bytes(output int unsigned first_edge);
      first_edge = cyc + 1;
      foreach (frame_q[i]) begin
         rx_data  = frame_q[i];
         rx_valid = 1'b1;
         tick();
      end
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   // Feeds of an idle, empty scheduler start 1+GAP edges after the first write, then every GAP.
   task automatic feed_phase(input int unsigned first_edge, output int unsigned e);
      int unsigned n;
      n = frame_q.size();
      for (int i = 0; i < 3000 && feed_q.size() < n; i++) tick();
      check("feed_arrival", feed_q.size() >= n, 1);
      e = cyc;
      if (feed_q.size() >= n) begin
         for (int unsigned i = 0; i < n; i++) begin
            check("feed_byte", feed_q[i].b, frame_q[i]);
            check("feed_time", feed_q[i].t, first_edge + 1 + GAP + i * GAP);
         end
         e = feed_q[n-1].t;
      end
      check("wait_busy", busy, 1);
   endtask

   task automatic verdict_phase(input int kind, input int unsigned sdelay, input int unsigned e);
      if (kind < 2) begin
         repeat (sdelay) tick();
         check("pre_strobe_txv", tx_valid, 0);
         output_strobe  = 1'b1;
         sequence_valid = (kind == 0);
         tick();
         output_strobe  = 1'b0;
         sequence_valid = 1'b0;
         exp_res = (kind == 0) ? 8'h59 : 8'h4E;
      end else begin
         while (cyc < e + TIMEOUT - 1) tick();
         check("pre_timeout_txv", tx_valid, 0);
         tick();
         exp_res = 8'h54;
      end
      check("verdict_txv", tx_valid, 1);
      check("verdict_txd", tx_data, exp_res);
   endtask

   task automatic resp_phase(input int unsigned rdelay, input int unsigned n_feeds,
                             output int unsigned h);
      repeat (rdelay) begin
         output_strobe  = 1'($urandom_range(0, 1));
         sequence_valid = 1'($urandom_range(0, 1));
         tick();
         check("hold_txv", tx_valid, 1);
         check("hold_txd", tx_data, exp_res);
      end
      output_strobe  = 1'b0;
      sequence_valid = 1'b0;
      check("feed_count", feed_q.size(), n_feeds);
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      h = cyc;
      if (exp_res == 8'h59) begin
         if (exp_pass < 255) exp_pass++;
      end else if (exp_fail < 255) begin
         exp_fail++;
      end
      check("post_hs_txv", tx_valid, 0);
      check("post_hs_busy", busy, 0);
      check("pass_cnt", pass_cnt, exp_pass);
      check("fail_cnt", fail_cnt, exp_fail);
      feed_q.delete();
   endtask

   task automatic run_frame(input int kind, input int unsigned sdelay, input int unsigned rdelay);
      int unsigned k0, e, h;
      feed_q.delete();
      send_bytes(k0);
      feed_phase(k0, e);
      verdict_phase(kind, sdelay, e);
      resp_phase(rdelay, frame_q.size(), h);
   endtask

   initial begin
      int unsigned k0, e, h, n_prev, n_at;
      bit          ovf_exp;

      rst = 1'b1; rx_data = '0; rx_valid = 1'b0; sequence_valid = 1'b0;
      output_strobe = 1'b0; tx_ready = 1'b0;
      repeat (3) tick();
      check_zero_outputs("reset");
      rst = 1'b0;
      tick();

      load_str("{1A2B+3C4D}");
      run_frame(0, 5, 3);
      load_str("{1X2Y+3Z4W}");
      run_frame(1, 12, 0);
      build_frame(6, 1'b1);
      run_frame(2, 0, 2);
      build_frame(9, 1'b0);
      run_frame(0, 20, 50);

      // 20-byte burst lands while the previous verdict is stalled, so nothing drains the FIFO.
      check("ovf_before", overflow, 0);
      build_frame(4, 1'b1);
      n_prev = frame_q.size();
      feed_q.delete();
      send_bytes(k0);
      feed_phase(k0, e);
      verdict_phase(0, 4, e);
      burst_q.delete();
      for (int i = 0; i < 20; i++) burst_q.push_back((i == 15) ? 8'h00 : 8'($urandom_range(1, 255)));
      frame_q = burst_q;
      send_bytes(k0);
      kept_q.delete();
      ovf_exp = 1'b0;
      foreach (burst_q[i]) begin
         if (kept_q.size() < DEPTH) kept_q.push_back(burst_q[i]);
         else ovf_exp = 1'b1;
      end
      check("burst_txv", tx_valid, 1);
      check("burst_txd", tx_data, exp_res);
      check("burst_ovf", overflow, ovf_exp);
      resp_phase(0, n_prev, h);
      frame_q = kept_q;
      feed_phase(h, e);
      verdict_phase(0, 3, e);
      resp_phase(4, DEPTH, h);
      check("ovf_sticky", overflow, 1);

      load_str("{1A2B+3C4D}");
      feed_q.delete();
      send_bytes(k0);
      for (int i = 0; i < 200 && feed_q.size() < 4; i++) tick();
      check("midframe_feeds", feed_q.size() >= 4, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_zero_outputs("midrst");
      n_at = feed_q.size();
      exp_pass = 0;
      exp_fail = 0;
      repeat (3 * GAP) tick();
      check("flush_no_feed", feed_q.size(), n_at);
      check("flush_idle", busy, 0);
      run_frame(0, 7, 1);

      for (int r = 0; r < 6; r++) begin
         build_frame($urandom_range(1, 12), 1'($urandom_range(0, 1)));
         run_frame(int'($urandom_range(0, 2)), $urandom_range(0, 40), $urandom_range(0, 20));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
